// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the centisecond BCD stopwatch.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int              BCD_W      = 4;
  localparam int              BCD_DIGITS = 4;
  localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;

  // Adds one to a 4-digit packed BCD value; bit 16 is the carry out of the top digit.
  function automatic logic [16:0] bcd_inc16(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (c) begin
        if (v[i*BCD_W +: BCD_W] == BCD_MAX) begin
          r[i*BCD_W +: BCD_W] = '0;
        end else begin
          r[i*BCD_W +: BCD_W] = v[i*BCD_W +: BCD_W] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises, debounces and rising-edge-detects one raw push-button.
// Latency: stable raw edge to rise_p is 2 sync + DB_CYCLES + 1 cycles.
// Backpressure: none; rise_p is a single-cycle pulse that is not held.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_p
);

  localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] db_cnt;
  logic          level_q;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Debounced level follows the synced level only after it has differed for DB_CYCLES cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync_q2 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      db_cnt <= '0;
      level  <= sync_q2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Registered one-cycle pulse on a debounced 0->1 transition only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
      rise_p  <= 1'b0;
    end else begin
      level_q <= level;
      rise_p  <= level & ~level_q;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Centisecond stopwatch (00.00..99.99, packed BCD) driven by start/stop and clear buttons.
// Latency: seg updates on the edge where the prescaler sits at TICK_DIV-1 in RUN.
// Backpressure: none; the display side samples seg whenever it likes.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 1_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  output logic [15:0] seg,
  output logic        running,
  output logic        ovf
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc;
  logic          tick;
  logic          clear_all;
  logic          start_fresh;
  logic          ss_p;
  logic          clr_p;
  logic          ss_level;
  logic          clr_level;
  logic          unused_levels;
  logic [16:0]   seg_inc;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_ss (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_start_stop),
    .level  (ss_level),
    .rise_p (ss_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_clear),
    .level  (clr_level),
    .rise_p (clr_p)
  );

  // Only the edge pulses drive this block; the debounced levels are not needed here.
  assign unused_levels = ss_level ^ clr_level;

  assign tick    = (state_q == RUN) && (presc == PRESC_LAST);
  assign seg_inc = bcd_inc16(seg);

  // State register; running mirrors the next state so both change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
    end
  end

  // Next state: clear beats start/stop when stopped, start/stop beats clear when running.
  always_comb begin
    state_d     = state_q;
    clear_all   = 1'b0;
    start_fresh = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_p) begin
          clear_all = 1'b1;
        end else if (ss_p) begin
          state_d     = RUN;
          start_fresh = 1'b1;
        end
      end
      RUN: begin
        if (ss_p) state_d = PAUSE;
      end
      PAUSE: begin
        if (clr_p) begin
          state_d   = IDLE;
          clear_all = 1'b1;
        end else if (ss_p) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        clear_all = 1'b1;
      end
    endcase
  end

  // Prescaler counts only in RUN; resuming from PAUSE keeps the partial centisecond.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (clear_all || start_fresh) begin
      presc <= '0;
    end else if (state_q == RUN) begin
      if (presc == PRESC_LAST) presc <= '0;
      else                     presc <= presc + 1'b1;
    end
  end

  // BCD time register; wrapping past 99.99 sets the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= '0;
      ovf <= 1'b0;
    end else if (clear_all) begin
      seg <= '0;
      ovf <= 1'b0;
    end else if (tick) begin
      seg <= seg_inc[15:0];
      if (seg_inc[16]) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_start_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic [15:0] seg;
  logic        running;
  logic        ovf;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int ss_cnt = 0;
  int ss_at  = 0;
  int clr_cnt = 0;
  int base;
  int s0;
  int c0;

  stopwatch_bcd #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .seg            (seg),
    .running        (running),
    .ovf            (ovf)
  );

  always #5 clk = ~clk;

  // Edge counter and pulse monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc <= cyc + 1;
    if (dut.ss_p) begin
      ss_cnt <= ss_cnt + 1;
      ss_at  <= cyc + 1;
    end
    if (dut.clr_p) clr_cnt <= clr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_seg(input logic [15:0] v, input int budget, input string tag);
    int i;
    i = 0;
    while (seg !== v && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(seg), 32'(v));
  endtask

  initial begin
    // Reset values, then quiet after release.
    step(3);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    reset = 1'b1;
    step(5);
    check("idle_seg", 32'(seg), 32'h0);
    check("idle_running", 32'(running), 32'h0);

    // Start: pulse 6 cycles after raw edge, RUN on the 7th, tick every 4.
    base = cyc;
    s0   = ss_cnt;
    btn_start_stop = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check("start_running", 32'(running), 32'(k >= 7));
      check("start_seg", 32'(seg), (k >= 7) ? 32'((k - 7) / 4) : 32'd0);
      if (k == 10) btn_start_stop = 1'b0;
    end
    check("start_pulses", 32'(ss_cnt - s0), 32'd1);
    check("start_pulse_lat", 32'(ss_at - base), 32'd6);

    // Digit carries and wrap.
    wait_seg(16'h0009, 100, "reach_0009");
    step(3);
    check("hold_0009", 32'(seg), 32'h0009);
    step(1);
    check("carry_0010", 32'(seg), 32'h0010);
    wait_seg(16'h0999, 5000, "reach_0999");
    step(3);
    check("hold_0999", 32'(seg), 32'h0999);
    step(1);
    check("carry_1000", 32'(seg), 32'h1000);
    wait_seg(16'h9999, 40000, "reach_9999");
    check("ovf_before_wrap", 32'(ovf), 32'h0);
    step(3);
    check("hold_9999", 32'(seg), 32'h9999);
    step(1);
    check("wrap_seg", 32'(seg), 32'h0000);
    check("wrap_ovf", 32'(ovf), 32'h1);
    check("wrap_running", 32'(running), 32'h1);

    // Clear alone in RUN is ignored.
    c0 = clr_cnt;
    btn_clear = 1'b1;
    step(10);
    btn_clear = 1'b0;
    step(10);
    check("run_clr_pulse", 32'(clr_cnt - c0), 32'd1);
    check("run_clr_running", 32'(running), 32'h1);
    check("run_clr_seg", 32'(seg), 32'h0005);
    check("run_clr_ovf", 32'(ovf), 32'h1);

    // Both buttons in RUN: pause with prescaler left at 2.
    step(3);
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    step(7);
    check("both_run_running", 32'(running), 32'h0);
    check("both_run_seg", 32'(seg), 32'h0007);
    step(3);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    step(20);
    check("pause_hold_seg", 32'(seg), 32'h0007);
    check("pause_running", 32'(running), 32'h0);
    check("pause_ovf", 32'(ovf), 32'h1);

    // Resume: next tick 2 cycles after RUN, then every 4.
    btn_start_stop = 1'b1;
    step(7);
    check("resume_running", 32'(running), 32'h1);
    check("resume_seg0", 32'(seg), 32'h0007);
    step(1);
    check("resume_seg1", 32'(seg), 32'h0007);
    step(1);
    check("resume_tick", 32'(seg), 32'h0008);
    step(4);
    check("resume_next", 32'(seg), 32'h0009);
    btn_start_stop = 1'b0;
    step(20);

    // Pause then clear.
    btn_start_stop = 1'b1;
    step(10);
    btn_start_stop = 1'b0;
    step(10);
    check("pause2_running", 32'(running), 32'h0);
    check("pause2_ovf", 32'(ovf), 32'h1);
    btn_clear = 1'b1;
    step(7);
    check("clear_seg", 32'(seg), 32'h0);
    check("clear_ovf", 32'(ovf), 32'h0);
    check("clear_running", 32'(running), 32'h0);
    step(3);
    btn_clear = 1'b0;
    step(20);

    // Both buttons in IDLE: clear wins, stay IDLE.
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    step(10);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    step(10);
    check("both_idle_running", 32'(running), 32'h0);
    check("both_idle_seg", 32'(seg), 32'h0);
    step(10);

    // Bounced press: one pulse, 6 cycles after the last raw edge.
    base = cyc;
    s0   = ss_cnt;
    btn_start_stop = 1'b1; step(1);
    btn_start_stop = 1'b0; step(1);
    btn_start_stop = 1'b1; step(1);
    btn_start_stop = 1'b0; step(1);
    btn_start_stop = 1'b1;
    step(10);
    check("bounce_pulses", 32'(ss_cnt - s0), 32'd1);
    check("bounce_pulse_at", 32'(ss_at - base), 32'd10);
    check("bounce_running", 32'(running), 32'h1);
    step(5);
    btn_start_stop = 1'b0;
    step(20);
    check("bounce_counting", 32'(seg != 16'h0), 32'h1);

    // Async reset mid-count with a press pending in the debouncer.
    s0 = ss_cnt;
    btn_start_stop = 1'b1;
    step(4);
    #2 reset = 1'b0;
    #1;
    check("arst_seg", 32'(seg), 32'h0);
    check("arst_running", 32'(running), 32'h0);
    check("arst_ovf", 32'(ovf), 32'h0);
    btn_start_stop = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(15);
    check("post_arst_running", 32'(running), 32'h0);
    check("post_arst_seg", 32'(seg), 32'h0);
    check("post_arst_no_pulse", 32'(ss_cnt - s0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
